pio_gpio_bank: RTL and testbench
================================

Name: pio_gpio_bank

Overview:
Parametrised GPIO pin bank for one PIO block. It synchronises raw pad inputs and presents an IN-mapped view rotated by a configurable base. It holds registered output-value and output-enable (pindir) state, updated through OUT, SET and PINDIRS write ports with wrap-around pin mapping. It also produces a registered WAIT-on-pin condition for the state machine. It sits between the PIO execution unit and the top-level pad buffers; tristate IOBUFs live outside this block.

Parameters:
NUM_PINS, 32, pin count; power of two in {4, 8, 16, 32}; IDXW = log2(NUM_PINS)
SYNC_STAGES, 2, input synchroniser depth; range 1..3

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
pins_in  input  NUM_PINS  raw pad inputs
pins_out  output  NUM_PINS  registered output values to pads
pins_oe  output  NUM_PINS  registered output enables (1 = drive)
cfg_in_base  input  IDXW  IN mapping base pin
cfg_out_base  input  IDXW  OUT/PINDIRS mapping base pin
cfg_out_count  input  6  OUT/PINDIRS pin count, 0..32
cfg_set_base  input  IDXW  SET mapping base pin
cfg_set_count  input  3  SET pin count, 0..5
rd_data  output  NUM_PINS  synchronised inputs rotated right by cfg_in_base
out_we  input  1  write out_data into output-value register via OUT map
out_data  input  NUM_PINS  OUT data; bit i targets pin (cfg_out_base+i) mod NUM_PINS
dir_we  input  1  write dir_data into pindir register via OUT map
dir_data  input  NUM_PINS  pindir data, same mapping as out_data
set_we  input  1  SET write strobe
set_dir  input  1  0 = SET targets output values; 1 = SET targets pindirs
set_data  input  5  SET data; bit i targets pin (cfg_set_base+i) mod NUM_PINS
wait_pin  input  IDXW  pin index for WAIT condition
wait_pol  input  1  required level for WAIT
wait_met  output  1  registered: sync_in[wait_pin] == wait_pol

Behaviour:
- Reset (async assert on reset_n low):
  - all synchroniser flops, out_reg, dir_reg and wait_met clear to 0 immediately.
  - pins_out = 0, pins_oe = 0, so all pins are inputs.
  - A reset mid-write discards the write.
- Synchroniser: pins_in passes through SYNC_STAGES flops to form sync_in. A pad change is visible on rd_data exactly SYNC_STAGES clock edges later.
- rd_data: combinational rotate-right of sync_in by cfg_in_base. Bit i = sync_in[(cfg_in_base+i) mod NUM_PINS]. No masking; consumer applies IN count.
- OUT map:
  - effective count = min(cfg_out_count, NUM_PINS).
  - For i < effective count, pin (cfg_out_base+i) mod NUM_PINS is targeted. Indices wrap past NUM_PINS-1 to 0.
  - count 0 means the write is a no-op.
  - Untargeted pins hold their value.
- out_we: out_reg[target] <= out_data[i] at the next edge.
- dir_we: dir_reg[target] <= dir_data[i] at the next edge. out_we and dir_we are independent and may fire the same cycle.
- set_we:
  - effective count = min(cfg_set_count, 5).
  - Writes set_data[i] into out_reg (set_dir = 0) or dir_reg (set_dir = 1) at pin (cfg_set_base+i) mod NUM_PINS.
- Conflict rule: if SET and OUT/PINDIRS target the same bit of the same register in one cycle, SET wins. Non-overlapping bits from both writes all take effect.
- pins_out = out_reg, pins_oe = dir_reg, so output latency is 1 cycle from the write strobe. out_reg is maintained regardless of oe.
- wait_met: registered every cycle from sync_in[wait_pin] == wait_pol. Latency from pad is SYNC_STAGES+1 edges.
- Out-of-range cfg values are not possible by width. A count above the limit clamps; it never wraps twice or writes a pin twice.

Optional Feature:
PIO_GPIO_EDGE_EN
- Defined:
  - Adds outputs edge_rise[NUM_PINS] and edge_fall[NUM_PINS], and input edge_clr[NUM_PINS].
  - Edges are detected on sync_in versus a one-cycle-delayed copy.
  - Flags are sticky and cleared by write-1 on edge_clr.
  - A new edge in the same cycle as its clear leaves the flag set.
  - Flags reset to 0. The delayed copy resets to 0, so a pin high at reset release raises edge_rise after synchronisation.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset: drive out_we/dir_we with all-ones, assert reset_n low mid-cycle -> pins_out = 0, pins_oe = 0, wait_met = 0 immediately, and they stay 0 after release.
- Input latency/rotation: NUM_PINS = 32, SYNC_STAGES = 2, pins_in = 0x0000_0001, cfg_in_base = 31 -> rd_data = 0x0000_0002 exactly 2 edges after the change.
- OUT wrap: cfg_out_base = 30, cfg_out_count = 4, out_data = 0xF, out_we for 1 cycle -> pins_out = 0xC000_0003 next cycle; other bits unchanged.
- SET/PINDIRS: cfg_set_base = 4, cfg_set_count = 3, set_dir = 1, set_data = 0b101 -> pins_oe bits 4 and 6 set, bit 5 clear. cfg_set_count = 7 clamps to 5 pins.
- Conflict: same cycle out_we (base 0, count 8, data 0x00) and set_we (base 2, count 2, set_dir = 0, data 0b11) -> pins_out[7:0] = 0x0C.
- WAIT: wait_pin = 9, wait_pol = 1, raise pins_in[9] -> wait_met rises 3 edges later; it falls 3 edges after pins_in[9] drops.

Source files
------------

// File: rtl/pio_gpio_bank.sv
// GPIO pin bank for one PIO block: input synchroniser with rotated IN view, OUT/SET/PINDIRS
// pin mapping with wrap-around, and a registered WAIT-on-pin condition. Optional sticky edge
// flags are built when PIO_GPIO_EDGE_EN is defined.
module pio_gpio_bank #(
  parameter int NUM_PINS    = 32,
  parameter int SYNC_STAGES = 2,
  localparam int IDXW       = $clog2(NUM_PINS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_PINS-1:0] pins_in,
  output logic [NUM_PINS-1:0] pins_out,
  output logic [NUM_PINS-1:0] pins_oe,
  input  logic [IDXW-1:0]     cfg_in_base,
  input  logic [IDXW-1:0]     cfg_out_base,
  input  logic [5:0]          cfg_out_count,
  input  logic [IDXW-1:0]     cfg_set_base,
  input  logic [2:0]          cfg_set_count,
  output logic [NUM_PINS-1:0] rd_data,
  input  logic                out_we,
  input  logic [NUM_PINS-1:0] out_data,
  input  logic                dir_we,
  input  logic [NUM_PINS-1:0] dir_data,
  input  logic                set_we,
  input  logic                set_dir,
  input  logic [4:0]          set_data,
  input  logic [IDXW-1:0]     wait_pin,
  input  logic                wait_pol,
`ifdef PIO_GPIO_EDGE_EN
  output logic [NUM_PINS-1:0] edge_rise,
  output logic [NUM_PINS-1:0] edge_fall,
  input  logic [NUM_PINS-1:0] edge_clr,
`endif
  output logic                wait_met
);

  // SET can never address more pins than the bank has, so it cannot wrap onto itself.
  localparam int         SET_MAX = (NUM_PINS < 5) ? NUM_PINS : 5;
  localparam logic [6:0] NP7     = 7'(NUM_PINS);

  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] sync_in;
  logic [NUM_PINS-1:0] out_q, out_d, dir_q, dir_d;
  logic                wait_q, wait_d;
  logic [6:0]          out_cnt;
  logic [2:0]          set_cnt;
  logic [NUM_PINS-1:0] out_map, out_val, dir_val, set_map, set_val;
  logic [NUM_PINS-1:0] wr_out, wr_dir, wr_set;

  assign sync_in  = sync_q[SYNC_STAGES-1];
  assign pins_out = out_q;
  assign pins_oe  = dir_q;
  assign wait_met = wait_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pins_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      rd_data[i] = sync_in[cfg_in_base + IDXW'(i)];
    end
  end

  always_comb begin
    out_cnt = ({1'b0, cfg_out_count} > NP7) ? NP7 : {1'b0, cfg_out_count};
    set_cnt = (cfg_set_count > 3'(SET_MAX)) ? 3'(SET_MAX) : cfg_set_count;
    out_map = '0;
    out_val = '0;
    dir_val = '0;
    set_map = '0;
    set_val = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (7'(i) < out_cnt) begin
        out_map[cfg_out_base + IDXW'(i)] = 1'b1;
        out_val[cfg_out_base + IDXW'(i)] = out_data[i];
        dir_val[cfg_out_base + IDXW'(i)] = dir_data[i];
      end else begin
        out_map = out_map;
      end
    end
    for (int i = 0; i < SET_MAX; i++) begin
      if (3'(i) < set_cnt) begin
        set_map[cfg_set_base + IDXW'(i)] = 1'b1;
        set_val[cfg_set_base + IDXW'(i)] = set_data[i];
      end else begin
        set_map = set_map;
      end
    end
  end

  // SET is applied after OUT/PINDIRS so it wins on any overlapping bit.
  always_comb begin
    wr_out = out_we ? out_map : '0;
    wr_dir = dir_we ? out_map : '0;
    wr_set = set_we ? set_map : '0;
    out_d  = (out_q & ~wr_out) | (out_val & wr_out);
    dir_d  = (dir_q & ~wr_dir) | (dir_val & wr_dir);
    if (set_dir) begin
      dir_d = (dir_d & ~wr_set) | (set_val & wr_set);
    end else begin
      out_d = (out_d & ~wr_set) | (set_val & wr_set);
    end
    wait_d = (sync_in[wait_pin] == wait_pol);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= '0;
      dir_q  <= '0;
      wait_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      wait_q <= wait_d;
    end
  end

`ifdef PIO_GPIO_EDGE_EN
  logic [NUM_PINS-1:0] prev_q, rise_q, rise_d, fall_q, fall_d;

  assign edge_rise = rise_q;
  assign edge_fall = fall_q;

  // A fresh edge is OR-ed in after the clear, so it survives a same-cycle clear.
  always_comb begin
    rise_d = (rise_q & ~edge_clr) | (sync_in & ~prev_q);
    fall_d = (fall_q & ~edge_clr) | (~sync_in & prev_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= sync_in;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
`endif

endmodule

// File: tb/tb_pio_gpio_bank.sv
// Randomised bench for pio_gpio_bank against a per-pin reference model with directed corner cases.
module tb_pio_gpio_bank;
  localparam int N = 32;
  localparam int S = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  pins_in, pins_out, pins_oe, rd_data, out_data, dir_data;
  logic [4:0]    cfg_in_base, cfg_out_base, cfg_set_base, wait_pin;
  logic [5:0]    cfg_out_count;
  logic [2:0]    cfg_set_count;
  logic          out_we, dir_we, set_we, set_dir, wait_pol, wait_met;
  logic [4:0]    set_data;

  pio_gpio_bank #(.NUM_PINS(N), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset_n(reset_n), .pins_in(pins_in), .pins_out(pins_out), .pins_oe(pins_oe),
    .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base), .cfg_out_count(cfg_out_count),
    .cfg_set_base(cfg_set_base), .cfg_set_count(cfg_set_count), .rd_data(rd_data),
    .out_we(out_we), .out_data(out_data), .dir_we(dir_we), .dir_data(dir_data),
    .set_we(set_we), .set_dir(set_dir), .set_data(set_data),
    .wait_pin(wait_pin), .wait_pol(wait_pol), .wait_met(wait_met)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: pad samples still in flight, plus pin-level register images.
  logic [N-1:0] m_hist[$];
  logic [N-1:0] m_out, m_dir;
  logic         m_wait;

  task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist.delete();
    for (int k = 0; k < S; k++) m_hist.push_back('0);
    m_out  = '0;
    m_dir  = '0;
    m_wait = 1'b0;
  endtask

  task automatic model_edge();
    logic [N-1:0] o, d;
    int cnt, tgt;
    o = m_out;
    d = m_dir;
    m_wait = (m_hist[0][wait_pin] == wait_pol);
    cnt = (int'(cfg_out_count) > N) ? N : int'(cfg_out_count);
    for (int i = 0; i < cnt; i++) begin
      tgt = (int'(cfg_out_base) + i) % N;
      if (out_we) o[tgt] = out_data[i];
      if (dir_we) d[tgt] = dir_data[i];
    end
    cnt = (int'(cfg_set_count) > 5) ? 5 : int'(cfg_set_count);
    if (set_we) begin
      for (int i = 0; i < cnt; i++) begin
        tgt = (int'(cfg_set_base) + i) % N;
        if (set_dir) d[tgt] = set_data[i];
        else         o[tgt] = set_data[i];
      end
    end
    m_out = o;
    m_dir = d;
    m_hist.push_back(pins_in);
    void'(m_hist.pop_front());
  endtask

  task automatic check_all();
    logic [N-1:0] exp_rd;
    for (int i = 0; i < N; i++) exp_rd[i] = m_hist[0][(int'(cfg_in_base) + i) % N];
    check_eq("rd_data", rd_data, exp_rd);
    check_eq("pins_out", pins_out, m_out);
    check_eq("pins_oe", pins_oe, m_dir);
    check_eq("wait_met", {{(N-1){1'b0}}, wait_met}, {{(N-1){1'b0}}, m_wait});
  endtask

  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_all();
  endtask

  task automatic idle();
    out_we = 1'b0; dir_we = 1'b0; set_we = 1'b0;
  endtask

  task automatic mid_reset();
    out_we = 1'b1; dir_we = 1'b1; out_data = '1; dir_data = '1;
    cfg_out_base = 5'd0; cfg_out_count = 6'd32;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_out", pins_out, '0);
    check_eq("rst_oe", pins_oe, '0);
    check_eq("rst_wait", {{(N-1){1'b0}}, wait_met}, '0);
    @(negedge clock);
    idle();
    check_eq("rst_hold_out", pins_out, '0);
    reset_n = 1'b1;
    cycle();
    check_eq("post_rst_oe", pins_oe, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    pins_in = '0; out_data = '0; dir_data = '0; set_data = 5'd0;
    cfg_in_base = 5'd0; cfg_out_base = 5'd0; cfg_set_base = 5'd0; wait_pin = 5'd0;
    cfg_out_count = 6'd0; cfg_set_count = 3'd0; set_dir = 1'b0; wait_pol = 1'b0;
    idle();
    model_reset();
    #1;
    check_eq("init_out", pins_out, '0);
    check_eq("init_oe", pins_oe, '0);
    @(negedge clock);
    reset_n = 1'b1;
    cycle();
    mid_reset();

    pins_in = 32'h0000_0001; cfg_in_base = 5'd31;
    cycle();
    check_eq("rot_lat1", rd_data, 32'h0000_0000);
    cycle();
    check_eq("rot_lat2", rd_data, 32'h0000_0002);

    cfg_out_base = 5'd30; cfg_out_count = 6'd4; out_data = 32'h0000_000F; out_we = 1'b1;
    cycle();
    idle();
    check_eq("out_wrap", pins_out, 32'hC000_0003);

    cfg_set_base = 5'd4; cfg_set_count = 3'd3; set_dir = 1'b1; set_data = 5'b00101; set_we = 1'b1;
    cycle();
    check_eq("set_dir", pins_oe, 32'h0000_0050);
    cfg_set_count = 3'd7; set_data = 5'b11111;
    cycle();
    idle();
    check_eq("set_clamp", pins_oe, 32'h0000_01F0);

    cfg_out_base = 5'd0; cfg_out_count = 6'd8; out_data = '0; out_we = 1'b1;
    cfg_set_base = 5'd2; cfg_set_count = 3'd2; set_dir = 1'b0; set_data = 5'b00011; set_we = 1'b1;
    cycle();
    idle();
    check_eq("conflict", {24'd0, pins_out[7:0]}, 32'h0000_000C);

    pins_in = '0; wait_pin = 5'd9; wait_pol = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    pins_in[9] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("wait_rise", {31'd0, wait_met}, (k == 2) ? 32'd1 : 32'd0);
    end
    pins_in[9] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("wait_fall", {31'd0, wait_met}, (k == 2) ? 32'd0 : 32'd1);
    end

    for (int c = 0; c < 600; c++) begin
      if (c == 300) mid_reset();
      if ($urandom_range(0, 3) != 0) pins_in = $urandom();
      cfg_in_base = 5'($urandom()); cfg_out_base = 5'($urandom()); cfg_set_base = 5'($urandom());
      cfg_out_count = 6'($urandom()); cfg_set_count = 3'($urandom());
      out_we = 1'($urandom()); dir_we = 1'($urandom()); set_we = 1'($urandom());
      set_dir = 1'($urandom()); set_data = 5'($urandom());
      out_data = $urandom(); dir_data = $urandom();
      wait_pin = 5'($urandom()); wait_pol = 1'($urandom());
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
